// File: rtl/uart_pkg.sv
// Shared UART constants: oversampling ratio, receiver state codes,
// baud divider helper and the ASCII digit offset used by the transmitter.
package uart_pkg;

  localparam int unsigned OVS = 16;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  localparam logic [7:0] ASCII_OFFSET = 8'd48;

  // Clocks per oversample tick; integer division, caller keeps result >= 1.
  function automatic int unsigned calc_div(input int unsigned f, input int unsigned baud);
    return f / (baud * OVS);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Clear-able divider: one-clock tick every DIV clocks, restarted by clr.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Free-running count 0..DIV-1, forced back to 0 on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = ~clr & (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling, optional
// ASCII digit decode.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD  = 9600,
  parameter int unsigned F     = 50000000,
  parameter int unsigned ASCII = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV = calc_div(F, BAUD);

  logic       rx_q1;
  logic       rx_s;
  logic       rx_s_prev;
  logic       fell;
  logic [2:0] state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] rx_byte;
  logic       tick;
  logic       clr;

  // Two-flop synchronizer plus one delayed copy for edge detection; idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q1     <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_prev <= 1'b1;
    end else begin
      rx_q1     <= rx;
      rx_s      <= rx_q1;
      rx_s_prev <= rx_s;
    end
  end

  assign fell = rx_s_prev & ~rx_s;
  assign clr  = (state == IDLE) & fell;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign rx_byte = (ASCII != 0) ? (shift - ASCII_OFFSET) : shift;
  assign busy    = (state != IDLE);

  // Frame FSM: start validation, LSB-first data capture, stop check, break wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fell) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == 4'd7) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state    <= DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shift[bit_cnt] <= rx_s;
              bit_cnt        <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end
            end
          end
        end
        STOP: begin
          if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              data <= rx_byte;
              if (rx_s) begin
                valid <= 1'b1;
                state <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: raw and ASCII-decoding receivers share
// one serial line; a frame-level model predicts the strobe stream.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam real BIT_NS = 160.0;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data,   data_a;
  logic       valid,  valid_a;
  logic       frame_err, frame_err_a;
  logic       busy,   busy_a;

  uart_rx #(.BAUD(100000), .F(1600000), .ASCII(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  uart_rx #(.BAUD(100000), .F(1600000), .ASCII(1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data_a),
    .valid     (valid_a),
    .frame_err (frame_err_a),
    .busy      (busy_a)
  );

  typedef struct packed {
    logic        ferr;
    logic [7:0]  d;
    logic [31:0] cyc;
  } ev_t;

  ev_t obs_q[$], obs_a[$], exp_q[$], exp_a[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  both_cnt = 0;
  logic [7:0] last_raw = 8'h00;
  logic [7:0] last_a   = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid)       obs_q.push_back({1'b0, data,   32'(cyc)});
    if (frame_err)   obs_q.push_back({1'b1, data,   32'(cyc)});
    if (valid_a)     obs_a.push_back({1'b0, data_a, 32'(cyc)});
    if (frame_err_a) obs_a.push_back({1'b1, data_a, 32'(cyc)});
    if ((valid && frame_err) || (valid_a && frame_err_a)) both_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  // Reference: a frame with good stop yields valid, else frame_err; the
  // decoding receiver reports the byte less 48 modulo 256.
  task automatic expect_frame(input int b, input bit stop_ok);
    exp_q.push_back({~stop_ok, 8'(b), 32'd0});
    exp_a.push_back({~stop_ok, 8'((b + 256 - 48) % 256), 32'd0});
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"},   obs_q.size(), exp_q.size());
    check({tag, "_count_a"}, obs_a.size(), exp_a.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_kind"}, obs_q[i].ferr, exp_q[i].ferr);
      check({tag, "_data"}, obs_q[i].d,    exp_q[i].d);
    end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      check({tag, "_kind_a"}, obs_a[i].ferr, exp_a[i].ferr);
      check({tag, "_data_a"}, obs_a[i].d,    exp_a[i].d);
    end
    if (exp_q.size() > 0) last_raw = exp_q[exp_q.size()-1].d;
    if (exp_a.size() > 0) last_a   = exp_a[exp_a.size()-1].d;
    check({tag, "_hold"},   data,   last_raw);
    check({tag, "_hold_a"}, data_a, last_a);
    obs_q.delete(); obs_a.delete(); exp_q.delete(); exp_a.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input real per);
    rx = 1'b0;
    start_cyc = cyc;
    #(per);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(per);
    end
    rx = stop;
    #(per);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},   busy,   1'b0);
    check({tag, "_busy_a"}, busy_a, 1'b0);
  endtask

  initial begin
    int lat;
    logic [7:0] b;
    logic [7:0] rb;
    real per;
    bit ok;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",   data,        8'h00);
    check("rst_valid",  valid,       1'b0);
    check("rst_ferr",   frame_err,   1'b0);
    check("rst_busy",   busy,        1'b0);
    check("rst_data_a", data_a,      8'h00);
    check("rst_busy_a", busy_a,      1'b0);
    rst = 1'b0;
    idle(20);

    // Basic frame, latency and busy release.
    @(negedge clk);
    send_frame(8'h55, 1'b1, BIT_NS);
    idle(40);
    expect_frame(8'h55, 1'b1);
    lat = (obs_q.size() > 0) ? int'(obs_q[0].cyc) - start_cyc : -1;
    check("lat_55_in_154_155", (lat >= 154 && lat <= 155), 1'b1);
    compare_events("f55");
    check_idle("f55");

    // False start: 4-clock low glitch.
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check("fs_busy_seen", busy, 1'b1);
    repeat (6) @(negedge clk);
    check_idle("fs");
    idle(20);
    compare_events("fs");

    // Bad stop bit followed by a held break, then a normal frame.
    @(negedge clk);
    send_frame(8'hA3, 1'b0, BIT_NS);
    repeat (48) @(negedge clk);
    check("brk_busy",   busy,   1'b1);
    check("brk_busy_a", busy_a, 1'b1);
    expect_frame(8'hA3, 1'b0);
    compare_events("brk");
    idle(40);
    check_idle("brk");
    send_frame(8'h12, 1'b1, BIT_NS);
    idle(40);
    expect_frame(8'h12, 1'b1);
    compare_events("f12");

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    idle(40);
    expect_frame(8'h00, 1'b1);
    expect_frame(8'hFF, 1'b1);
    compare_events("b2b");

    // Asynchronous reset in the middle of bit 4.
    @(negedge clk);
    b = 8'h3C;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = b[4];
    #(BIT_NS / 2.0 + 3.0);
    rst = 1'b1;
    #1;
    check("arst_data",   data,   8'h00);
    check("arst_busy",   busy,   1'b0);
    check("arst_data_a", data_a, 8'h00);
    check("arst_busy_a", busy_a, 1'b0);
    rx = 1'b1;
    last_raw = 8'h00;
    last_a   = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(40);
    compare_events("arst");
    send_frame(8'h3C, 1'b1, BIT_NS);
    idle(40);
    expect_frame(8'h3C, 1'b1);
    compare_events("f3C");

    // ASCII digit decode.
    send_frame(8'h37, 1'b1, BIT_NS);
    idle(40);
    expect_frame(8'h37, 1'b1);
    compare_events("f37");

    // +/-6% rates: outside tolerance, only recovery to idle is required.
    send_frame(8'h37, 1'b1, 150.0);
    idle(60);
    send_frame(8'h37, 1'b1, 170.0);
    idle(60);
    check_idle("pm6");
    obs_q.delete(); obs_a.delete();

    // +/-3% rates must decode.
    send_frame(8'h37, 1'b1, BIT_NS * 0.97);
    idle(40);
    send_frame(8'h37, 1'b1, BIT_NS * 1.03);
    idle(40);
    expect_frame(8'h37, 1'b1);
    expect_frame(8'h37, 1'b1);
    compare_events("pm3");

    // Randomized frames: random byte, rate within tolerance, stop bit and gaps.
    for (int n = 0; n < 12; n++) begin
      rb = 8'($urandom_range(255));
      ok = ($urandom_range(3) != 0);
      case ($urandom_range(2))
        0:       per = BIT_NS * 0.97;
        1:       per = BIT_NS;
        default: per = BIT_NS * 1.03;
      endcase
      send_frame(rb, ok, per);
      expect_frame(rb, ok);
      if (!ok) begin
        repeat ($urandom_range(40)) @(negedge clk);
        idle(40);
      end else begin
        idle($urandom_range(30));
      end
    end
    idle(40);
    compare_events("rnd");
    check_idle("rnd");

    check("exclusive_strobes", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver that sits directly downstream of the UART transmitter and consumes the 8N1 line it produces: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Oversamples the line at 16x baud, validates the start bit and samples each bit at mid-period.
- Presents each received byte with a one-cycle valid strobe, or a framing-error strobe when the stop bit is bad.
- Optional ASCII-digit decode undoes the transmitter's '0' offset.

Parameters:
- BAUD, 9600: line bit rate, bits/s.
- F, 50000000: clk frequency, Hz.
- ASCII, 0: 1 = output received byte minus 8'd48 (mod 256); 0 = raw byte.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- rx  input  1  serial line, asynchronous to clk, idle high.
- data  output  8  last received byte; holds until the next frame completes.
- valid  output  1  one-cycle strobe: data updated, stop bit good.
- frame_err  output  1  one-cycle strobe: data updated, stop bit sampled 0.
- busy  output  1  high from accepted start edge until return to IDLE.

Behaviour:
- Reset: async assert forces IDLE; data=0, valid=0, frame_err=0, busy=0; synchronizer flops=1; tick divider and counters=0. Reset mid-frame discards the partial byte with no strobe.
- rx passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized rx_s. Falling edge = rx_s_prev=1 and rx_s=0.
- Oversample tick: DIV = F/(BAUD*16), integer division, must be >= 1. Tick is a 1-clk pulse every DIV clocks. The divider is cleared on the start edge so sampling phase aligns to the edge.
- tick_cnt is 4 bits, counts ticks within a bit. bit_cnt is 3 bits.
- IDLE: busy=0. On falling edge go to START, clear tick_cnt and divider, busy=1.
- START: after 8 ticks (mid start bit) sample rx_s.
  - rx_s=1: false start, go to IDLE, no strobe.
  - rx_s=0: go to DATA, clear tick_cnt and bit_cnt.
- DATA: every 16 ticks sample rx_s into shift[bit_cnt] (LSB first). After bit 7 go to STOP.
- STOP: after 16 ticks sample rx_s.
  - rx_s=1: data<=shift (or shift-48 when ASCII=1), valid=1 for exactly one clk, go to IDLE.
  - rx_s=0: data<=shift (same transform), frame_err=1 for one clk, go to WAIT_HIGH.
- WAIT_HIGH: busy stays 1; stay until rx_s=1, then go to IDLE. This prevents a break condition from re-triggering start detection.
- valid and frame_err are never high together.
- Latency: strobe occurs 9.5 bit periods after the start edge, plus 2-3 clk of synchronizer/edge delay.
- Back-to-back frames: IDLE is reached at mid stop bit, so a start edge immediately after the stop bit is detected.
- Baud mismatch up to ±3% must still decode correctly.

Decomposition:
- Shared package uart_pkg:
  - OVS=16.
  - State encoding: IDLE, START, DATA, STOP, WAIT_HIGH.
  - Function computing DIV from F and BAUD.
  - ASCII_OFFSET=8'd48, shared with the transmitter.
- One natural sub-module: uart_baud_tick, a clear-able divider producing the 1-clk tick, parameter DIV, ports clk/rst/clr/tick.
- Synchronizer, FSM and shift register stay inline.

Test Plan:
Bench uses F=1600000, BAUD=100000, giving DIV=1 and 16 clk per bit.
- Drive frame 0x55, good stop bit -> valid pulses once (1 clk), data=0x55, frame_err=0. Strobe lands 152+2..3 clk after the start edge; busy=0 afterwards.
- Drive rx low for 4 clk then high -> no valid/frame_err, busy returns to 0 within 12 clk, data unchanged.
- Drive 0xA3 with stop bit 0, hold rx low 48 clk, then idle, then 0x12 -> frame_err pulse with data=0xA3, no false frame during the low hold, then valid with data=0x12.
- Drive 0x00 and 0xFF back-to-back (no idle gap) -> two valid pulses, data 0x00 then 0xFF, no frame_err.
- Assert rst at bit 4 of frame 0x3C, release, send 0x3C again -> outputs 0 asynchronously, no strobe for the aborted frame, then valid with data=0x3C.
- ASCII=1, drive 0x37 -> data=0x07, valid=1. Repeat at bit period 15 and 17 clk (±6%, outside tolerance) and at 16±3% via fractional stimulus -> correct decode within ±3%.
